// File: rtl/mult_div_unit_if.sv
// Handshake bundle between the register file / controller
// and the iterative multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WL = 32
);
  logic [WL-1:0] MDU_Operand_A;
  logic [WL-1:0] MDU_Operand_B;
  logic [1:0]    MDU_Op;
  logic          MDU_Start;
  logic          MDU_Write_HI;
  logic          MDU_Write_LO;
  logic [WL-1:0] MDU_HI;
  logic [WL-1:0] MDU_LO;
  logic          MDU_Busy;
  logic          MDU_Done;

  modport master (
    output MDU_Operand_A,
    output MDU_Operand_B,
    output MDU_Op,
    output MDU_Start,
    output MDU_Write_HI,
    output MDU_Write_LO,
    input  MDU_HI,
    input  MDU_LO,
    input  MDU_Busy,
    input  MDU_Done
  );

  modport slave (
    input  MDU_Operand_A,
    input  MDU_Operand_B,
    input  MDU_Op,
    input  MDU_Start,
    input  MDU_Write_HI,
    input  MDU_Write_LO,
    output MDU_HI,
    output MDU_LO,
    output MDU_Busy,
    output MDU_Done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle.
module mult_div_unit #(
  parameter int WL = 32
) (
  input logic           CLK,
  input logic           RST,
  mult_div_unit_if.slave mdu
);

  localparam int CW = (WL > 2) ? $clog2(WL) : 1;
  localparam logic [CW-1:0] LAST = CW'(WL - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic          neg_q;
  logic          neg_r;
  logic          dz;
  logic [WL-1:0] a_raw;
  logic [WL-1:0] m;
  logic [WL-1:0] acc_hi;
  logic [WL-1:0] acc_lo;
  logic [WL-1:0] hi_q;
  logic [WL-1:0] lo_q;
  logic          busy_q;
  logic          done_q;

  logic          sgn;
  logic          a_neg;
  logic          b_neg;
  logic [WL-1:0] a_mag;
  logic [WL-1:0] b_mag;

  logic [WL:0]     add_sum;
  logic [WL:0]     rs;
  logic [WL-1:0]   diff;
  logic            ge;
  logic [WL-1:0]   step_hi;
  logic [WL-1:0]   step_lo;
  logic [2*WL-1:0] prod;
  logic [2*WL-1:0] prod_fix;
  logic [WL-1:0]   q_fix;
  logic [WL-1:0]   r_fix;
  logic [WL-1:0]   res_hi;
  logic [WL-1:0]   res_lo;

  assign sgn   = ~mdu.MDU_Op[0];
  assign a_neg = sgn & mdu.MDU_Operand_A[WL-1];
  assign b_neg = sgn & mdu.MDU_Operand_B[WL-1];
  assign a_mag = a_neg ? -mdu.MDU_Operand_A
                       : mdu.MDU_Operand_A;
  assign b_mag = b_neg ? -mdu.MDU_Operand_B
                       : mdu.MDU_Operand_B;

  assign mdu.MDU_HI   = hi_q;
  assign mdu.MDU_LO   = lo_q;
  assign mdu.MDU_Busy = busy_q;
  assign mdu.MDU_Done = done_q;

  // One iteration step plus sign fix-up of the would-be final value
  always_comb begin
    add_sum  = {1'b0, acc_hi}
             + {1'b0, (acc_lo[0] ? m : {WL{1'b0}})};
    rs       = {acc_hi, acc_lo[WL-1]};
    ge       = (rs >= {1'b0, m});
    diff     = rs[WL-1:0] - m;
    step_hi  = '0;
    step_lo  = '0;
    unique case (1'b1)
      op_q[1]: begin
        step_hi = ge ? diff : rs[WL-1:0];
        step_lo = {acc_lo[WL-2:0], ge};
      end
      !op_q[1]: begin
        step_hi = add_sum[WL:1];
        step_lo = {add_sum[0], acc_lo[WL-1:1]};
      end
      default: ;
    endcase
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -step_lo : step_lo;
    r_fix    = neg_r ? -step_hi : step_hi;
    res_hi   = prod_fix[2*WL-1:WL];
    res_lo   = prod_fix[WL-1:0];
    unique case (1'b1)
      op_q[1] && dz: begin
        res_hi = a_raw;
        res_lo = '1;
      end
      op_q[1] && !dz: begin
        res_hi = r_fix;
        res_lo = q_fix;
      end
      default: ;
    endcase
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      a_raw  <= '0;
      m      <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mdu.MDU_Start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            cnt    <= '0;
            op_q   <= mdu.MDU_Op;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= (mdu.MDU_Operand_B == '0);
            a_raw  <= mdu.MDU_Operand_A;
            acc_hi <= '0;
            if (mdu.MDU_Op[1]) begin
              m      <= b_mag;
              acc_lo <= a_mag;
            end else begin
              m      <= a_mag;
              acc_lo <= b_mag;
            end
          end else begin
            if (mdu.MDU_Write_HI)
              hi_q <= mdu.MDU_Operand_A;
            if (mdu.MDU_Write_LO)
              lo_q <= mdu.MDU_Operand_A;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a reference model
// pushes expected HI/LO on issue, popped on each Done.
module tb_mult_div_unit;

  logic CLK;
  logic RST;
  int   tests;
  int   fails;

  logic [63:0] sb[$];
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit_if #(.WL(32)) bus ();

  mult_div_unit #(.WL(32)) dut (
    .CLK(CLK),
    .RST(RST),
    .mdu(bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint      sa;
    longint      sb2;
    int          ia;
    int          ib;
    int          q;
    int          rm;
    logic [63:0] r;
    r = '0;
    case (op)
      2'd0: begin
        sa  = {{32{a[31]}}, a};
        sb2 = {{32{b[31]}}, b};
        r   = sa * sb2;
      end
      2'd1: r = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0)
          r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = {32'd0, 32'h8000_0000};
        else begin
          ia = a;
          ib = b;
          q  = ia / ib;
          rm = ia % ib;
          r  = {rm, q};
        end
      end
      default: begin
        if (b == 0)
          r = {a, 32'hFFFF_FFFF};
        else
          r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the Start edge.
  task automatic issue(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          wlo
  );
    bus.MDU_Op        = op;
    bus.MDU_Operand_A = a;
    bus.MDU_Operand_B = b;
    bus.MDU_Start     = 1'b1;
    bus.MDU_Write_LO  = wlo;
    sb.push_back(model(op, a, b));
    @(negedge CLK);
    bus.MDU_Start    = 1'b0;
    bus.MDU_Write_LO = 1'b0;
  endtask

  task automatic await_result(input string name, input bit disturb);
    int          k;
    bit          got;
    bit          busy_ok;
    bit          hold_ok;
    logic [63:0] e;
    k       = 0;
    got     = 0;
    busy_ok = bus.MDU_Busy;
    hold_ok = (bus.MDU_HI === exp_hi) && (bus.MDU_LO === exp_lo);
    while (k < 40 && !got) begin
      @(negedge CLK);
      k++;
      if (disturb && k == 5) begin
        bus.MDU_Start    = 1'b1;
        bus.MDU_Op       = 2'($urandom_range(0, 3));
        bus.MDU_Write_HI = 1'b1;
      end
      if (disturb && k == 6) begin
        bus.MDU_Start    = 1'b0;
        bus.MDU_Write_HI = 1'b0;
      end
      if (disturb && k >= 5) begin
        bus.MDU_Operand_A = $urandom;
        bus.MDU_Operand_B = $urandom;
      end
      if (bus.MDU_Done === 1'b1) begin
        got = 1;
      end else begin
        if (bus.MDU_Busy !== 1'b1) busy_ok = 0;
        if (bus.MDU_HI !== exp_hi || bus.MDU_LO !== exp_lo)
          hold_ok = 0;
      end
    end
    bus.MDU_Start    = 1'b0;
    bus.MDU_Write_HI = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s timeout: no Done within 40 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    tests++;
    if (k !== 32) begin
      fails++;
      $display("FAIL %s latency: got %0d want 32", name, k);
    end
    tests++;
    if (!busy_ok || bus.MDU_Busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy: got done-busy %b want 0, run-busy ok %b want 1",
               name, bus.MDU_Busy, busy_ok);
    end
    tests++;
    if (!hold_ok) begin
      fails++;
      $display("FAIL %s hold: HI/LO changed during run, want %h/%h",
               name, exp_hi, exp_lo);
    end
    e = sb.pop_front();
    tests++;
    if (bus.MDU_HI !== e[63:32] || bus.MDU_LO !== e[31:0]) begin
      fails++;
      $display("FAIL %s result: got HI=%h LO=%h want HI=%h LO=%h",
               name, bus.MDU_HI, bus.MDU_LO, e[63:32], e[31:0]);
    end
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    tests++;
    if (bus.MDU_HI !== 0 || bus.MDU_LO !== 0 ||
        bus.MDU_Busy !== 0 || bus.MDU_Done !== 0) begin
      fails++;
      $display("FAIL reset: got HI=%h LO=%h busy=%b done=%b want all 0",
               bus.MDU_HI, bus.MDU_LO, bus.MDU_Busy, bus.MDU_Done);
    end
    RST    = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    @(negedge CLK);
  endtask

  task automatic test_multu_max();
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    await_result("multu_max", 0);
    @(negedge CLK);
    tests++;
    if (bus.MDU_Done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: got %b want 0", bus.MDU_Done);
    end
  endtask

  task automatic test_signed();
    issue(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
    await_result("mult_neg", 0);
    @(negedge CLK);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    await_result("div_neg", 0);
    @(negedge CLK);
  endtask

  task automatic test_div_corner();
    issue(2'd3, 32'd100, 32'd0, 0);
    await_result("divu_zero", 0);
    @(negedge CLK);
    issue(2'd2, 32'hFFFF_FF9C, 32'd0, 0);
    await_result("div_zero", 0);
    @(negedge CLK);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    await_result("div_ovf", 0);
    @(negedge CLK);
  endtask

  task automatic test_ignore_in_run();
    issue(2'd1, 32'hDEAD_BEEF, 32'h0001_0003, 0);
    await_result("run_ignore", 1);
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    issue(2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    await_result("b2b_first", 0);
    issue(2'd2, 32'd12345, 32'hFFFF_FFF9, 0);
    await_result("b2b_second", 0);
    @(negedge CLK);
  endtask

  task automatic test_idle_writes();
    bus.MDU_Operand_A = 32'h1234_5678;
    bus.MDU_Write_HI  = 1'b1;
    @(negedge CLK);
    bus.MDU_Write_HI = 1'b0;
    exp_hi = 32'h1234_5678;
    tests++;
    if (bus.MDU_HI !== exp_hi || bus.MDU_LO !== exp_lo ||
        bus.MDU_Done !== 1'b0) begin
      fails++;
      $display("FAIL mthi: got HI=%h LO=%h done=%b want %h %h 0",
               bus.MDU_HI, bus.MDU_LO, bus.MDU_Done, exp_hi, exp_lo);
    end
    bus.MDU_Operand_A = 32'hCAFE_F00D;
    bus.MDU_Write_HI  = 1'b1;
    bus.MDU_Write_LO  = 1'b1;
    @(negedge CLK);
    bus.MDU_Write_HI = 1'b0;
    bus.MDU_Write_LO = 1'b0;
    exp_hi = 32'hCAFE_F00D;
    exp_lo = 32'hCAFE_F00D;
    tests++;
    if (bus.MDU_HI !== exp_hi || bus.MDU_LO !== exp_lo ||
        bus.MDU_Done !== 1'b0) begin
      fails++;
      $display("FAIL mthi_mtlo: got HI=%h LO=%h done=%b want %h %h 0",
               bus.MDU_HI, bus.MDU_LO, bus.MDU_Done, exp_hi, exp_lo);
    end
    issue(2'd3, 32'd1000, 32'd7, 1);
    await_result("start_wins", 0);
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_run();
    int dones;
    issue(2'd1, 32'hAAAA_5555, 32'h1234_4321, 0);
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    sb.delete();
    exp_hi = '0;
    exp_lo = '0;
    tests++;
    if (bus.MDU_Busy !== 0 || bus.MDU_HI !== 0 ||
        bus.MDU_LO !== 0 || bus.MDU_Done !== 0) begin
      fails++;
      $display("FAIL rst_mid: got busy=%b HI=%h LO=%h done=%b want 0",
               bus.MDU_Busy, bus.MDU_HI, bus.MDU_LO, bus.MDU_Done);
    end
    dones = 0;
    repeat (35) begin
      @(negedge CLK);
      if (bus.MDU_Done === 1'b1) dones++;
    end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL rst_nodone: got %0d done pulses want 0", dones);
    end
    issue(2'd1, 32'd6, 32'd7, 0);
    await_result("after_rst", 0);
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    for (int i = 0; i < 8; i++) begin
      op = 2'(i % 4);
      a  = $urandom;
      b  = (i >= 4) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i == 6) b = -b;
      issue(op, a, b, 0);
      await_result($sformatf("rand%0d", i), 0);
      @(negedge CLK);
    end
  endtask

  initial begin
    CLK   = 1'b0;
    RST   = 1'b1;
    tests = 0;
    fails = 0;
    bus.MDU_Operand_A = '0;
    bus.MDU_Operand_B = '0;
    bus.MDU_Op        = '0;
    bus.MDU_Start     = 1'b0;
    bus.MDU_Write_HI  = 1'b0;
    bus.MDU_Write_LO  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    test_reset();
    test_multu_max();
    test_signed();
    test_div_corner();
    test_ignore_in_run();
    test_back_to_back();
    test_idle_writes();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
